uart_mmio: RTL and testbench

- Memory-mapped register bridge between the core's data bus and the UART transceiver.
- Sits directly upstream of the UART TX FIFO and downstream of the UART RX FIFO.
- Converts single-beat bus reads and writes into the UART's tx_available/tx_ack and rx_pop/rx_ack handshakes.
- Holds one prefetched RX byte so software can poll a status bit, and raises a level interrupt when a byte is waiting.

---
 rtl/uart_mmio_if.sv | 21 ++
 rtl/uart_mmio.sv | 161 ++++++++++++++++
 tb/tb_uart_mmio.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_mmio_if.sv
// Single-beat core data bus as seen by the UART register bridge.
// The master holds a request until it sees the one-cycle mem_ready pulse.
interface uart_mmio_if;
  logic        mem_valid;
  logic        mem_write;
  logic [1:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_write, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_write, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/uart_mmio.sv
// Memory-mapped bridge between the core data bus and the UART FIFOs: a one-byte
// TX holding register, a one-byte prefetched RX buffer and a level interrupt.
module uart_mmio #(
  parameter bit IRQ_EN_RESET = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  uart_mmio_if.slave  bus,
  output logic        tx_available,
  output logic [7:0]  tx_data,
  input  logic        tx_ack,
  input  logic [7:0]  rx_data,
  output logic        rx_pop,
  input  logic        rx_ack,
  output logic        irq
);

  typedef enum logic {
    BUS_IDLE,
    BUS_RESP
  } bus_state_t;

  typedef enum logic [1:0] {
    RX_POP,
    RX_CHECK,
    RX_FULL
  } rx_state_t;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  bus_state_t  bus_state, bus_state_next;
  rx_state_t   rx_state, rx_state_next;

  logic [31:0] resp_data;
  logic        resp_pops_rx;
  logic [7:0]  tx_hold;
  logic        tx_hold_valid;
  logic [7:0]  rx_buf;
  logic        rx_buf_valid;
  logic        irq_en;

  logic        req;
  logic        push_req;
  logic        complete;
  logic        push_accept;
  logic        ctrl_write;
  logic        data_read_pops;
  logic        rx_capture;
  logic        rx_release;
  logic [31:0] read_value;
  logic        unused_bus_bits;

  assign unused_bus_bits = ^{bus.mem_wdata[31:8], bus.mem_wstrb[3:1]};

  // A strobed DATA write only stalls while the holding register is full and
  // the UART is not draining it this very cycle.
  always_comb begin
    req            = (bus_state == BUS_IDLE) && bus.mem_valid;
    push_req       = req && bus.mem_write && (bus.mem_addr == REG_DATA) && bus.mem_wstrb[0];
    complete       = req && !(push_req && tx_hold_valid && !tx_ack);
    push_accept    = complete && push_req;
    ctrl_write     = complete && bus.mem_write && (bus.mem_addr == REG_CTRL) && bus.mem_wstrb[0];
    data_read_pops = complete && !bus.mem_write && (bus.mem_addr == REG_DATA) && rx_buf_valid;

    read_value = '0;
    if (!bus.mem_write) begin
      case (bus.mem_addr)
        REG_DATA:   read_value = rx_buf_valid ? {1'b1, 23'b0, rx_buf} : 32'h0;
        REG_STATUS: read_value = {29'b0, irq_en, tx_hold_valid, rx_buf_valid};
        REG_CTRL:   read_value = {31'b0, irq_en};
        default:    read_value = '0;
      endcase
    end

    bus_state_next = bus_state;
    case (bus_state)
      BUS_IDLE: if (complete) bus_state_next = BUS_RESP;
      BUS_RESP: bus_state_next = BUS_IDLE;
      default:  bus_state_next = BUS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus_state    <= BUS_IDLE;
      resp_data    <= '0;
      resp_pops_rx <= 1'b0;
    end else begin
      bus_state <= bus_state_next;
      if (complete) begin
        resp_data    <= read_value;
        resp_pops_rx <= data_read_pops;
      end
    end
  end

  assign bus.mem_ready = (bus_state == BUS_RESP);
  assign bus.mem_rdata = (bus_state == BUS_RESP) ? resp_data : 32'h0;

  // A new byte loading in the same cycle as the ack keeps the register full.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_hold       <= '0;
      tx_hold_valid <= 1'b0;
    end else if (push_accept) begin
      tx_hold       <= bus.mem_wdata[7:0];
      tx_hold_valid <= 1'b1;
    end else if (tx_ack) begin
      tx_hold_valid <= 1'b0;
    end
  end

  assign tx_available = tx_hold_valid;
  assign tx_data      = tx_hold;

  // Prefetch loop: pop, wait one cycle for the registered ack, then either
  // hold the byte until software reads DATA or retry the pop.
  always_comb begin
    rx_capture    = (rx_state == RX_CHECK) && rx_ack;
    rx_release    = (rx_state == RX_FULL) && (bus_state == BUS_RESP) && resp_pops_rx;
    rx_state_next = rx_state;
    case (rx_state)
      RX_POP:   rx_state_next = RX_CHECK;
      RX_CHECK: rx_state_next = rx_ack ? RX_FULL : RX_POP;
      RX_FULL:  if (rx_release) rx_state_next = RX_POP;
      default:  rx_state_next = RX_POP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state     <= RX_POP;
      rx_buf       <= '0;
      rx_buf_valid <= 1'b0;
    end else begin
      rx_state <= rx_state_next;
      if (rx_capture) begin
        rx_buf       <= rx_data;
        rx_buf_valid <= 1'b1;
      end else if (rx_release) begin
        rx_buf_valid <= 1'b0;
      end
    end
  end

  // Gated by rst_n so no pop reaches the UART while reset is held.
  assign rx_pop = rst_n && (rx_state == RX_POP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_en <= IRQ_EN_RESET;
      irq    <= 1'b0;
    end else begin
      if (ctrl_write) irq_en <= bus.mem_wdata[0];
      irq <= irq_en & rx_buf_valid;
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
// Self-checking bench for uart_mmio: a UART-side model plus a transaction-level
// register model that is compared against the DUT every cycle.
module tb_uart_mmio;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_available;
  logic [7:0] tx_data;
  logic       tx_ack = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_pop;
  logic       rx_ack = 1'b0;
  logic       irq;

  uart_mmio_if bus();

  uart_mmio #(.IRQ_EN_RESET(1'b0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .tx_available (tx_available),
    .tx_data      (tx_data),
    .tx_ack       (tx_ack),
    .rx_data      (rx_data),
    .rx_pop       (rx_pop),
    .rx_ack       (rx_ack),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_ack_cyc = -1;
  int last_ready_cyc = -1;
  int tx_ack_delay = 2;
  logic [7:0] tx_sent[$];
  logic [7:0] rx_q[$];

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // UART TX side: acknowledges an offered byte after tx_ack_delay waiting cycles.
  initial begin
    int tx_wait;
    tx_wait = 0;
    forever begin
      @(negedge clk);
      if (rst_n && tx_available === 1'b1) begin
        if (tx_wait >= tx_ack_delay) begin
          tx_sent.push_back(tx_data);
          @(posedge clk); #1 tx_ack = 1'b1;
          @(posedge clk); #1 tx_ack = 1'b0;
          tx_wait = 0;
        end else begin
          tx_wait++;
        end
      end else begin
        tx_wait = 0;
      end
    end
  end

  // UART RX side: answers a pop with a registered ack when it has a byte.
  initial begin
    bit pop_now;
    forever begin
      @(negedge clk);
      pop_now = (rx_pop === 1'b1) && rst_n;
      @(posedge clk); #1;
      if (pop_now && rx_q.size() != 0) begin
        rx_ack  = 1'b1;
        rx_data = rx_q.pop_front();
      end else begin
        rx_ack  = 1'b0;
        rx_data = 8'h00;
      end
    end
  end

  // Register-map model: state describes the cycle after the next posedge.
  logic [7:0]  m_tx[$];
  bit          m_rx_full, m_irq_en, m_irq, m_resp, m_resp_pop, prev_pop;
  logic [7:0]  m_rx_byte;
  logic [31:0] m_rdata;

  always @(negedge clk) begin
    bit n_irq, n_resp, n_pop, n_full, n_irq_en, do_push, stall;
    logic [31:0] n_rdata;
    if (!rst_n) begin
      m_tx.delete();
      m_rx_full = 0; m_irq_en = 0; m_irq = 0; m_resp = 0; m_resp_pop = 0;
      m_rx_byte = 8'h00; m_rdata = 32'h0; prev_pop = 0;
    end else begin
      checkOutput("mem_ready", {31'b0, bus.mem_ready}, {31'b0, m_resp});
      checkOutput("mem_rdata", bus.mem_rdata, m_resp ? m_rdata : 32'h0);
      checkOutput("tx_available", {31'b0, tx_available}, {31'b0, m_tx.size() != 0});
      if (m_tx.size() != 0) checkOutput("tx_data", {24'b0, tx_data}, {24'b0, m_tx[0]});
      checkOutput("irq", {31'b0, irq}, {31'b0, m_irq});
      checkOutput("rx_pop_back_to_back", {31'b0, rx_pop && prev_pop}, 32'h0);
      checkOutput("rx_pop_while_full", {31'b0, rx_pop && m_rx_full}, 32'h0);

      n_irq = m_irq_en && m_rx_full;
      n_resp = 0; n_pop = 0; n_rdata = 32'h0; do_push = 0;
      n_full = m_rx_full; n_irq_en = m_irq_en;
      if (!m_resp && bus.mem_valid) begin
        stall = bus.mem_write && bus.mem_addr == 2'd0 && bus.mem_wstrb[0] && m_tx.size() != 0 && !tx_ack;
        if (!stall) begin
          n_resp = 1;
          if (!bus.mem_write) begin
            case (bus.mem_addr)
              2'd0: if (m_rx_full) begin n_rdata = {1'b1, 23'b0, m_rx_byte}; n_pop = 1; end
              2'd1: n_rdata = {29'b0, m_irq_en, m_tx.size() != 0, m_rx_full};
              2'd2: n_rdata = {31'b0, m_irq_en};
              default: n_rdata = 32'h0;
            endcase
          end else if (bus.mem_wstrb[0]) begin
            if (bus.mem_addr == 2'd0) do_push = 1;
            if (bus.mem_addr == 2'd2) n_irq_en = bus.mem_wdata[0];
          end
        end
      end
      if (tx_ack) last_ack_cyc = cyc;
      if (tx_ack && m_tx.size() != 0) void'(m_tx.pop_front());
      if (do_push) m_tx.push_back(bus.mem_wdata[7:0]);
      if (m_resp && m_resp_pop) n_full = 0;
      if (rx_ack) begin n_full = 1; m_rx_byte = rx_data; end
      m_irq = n_irq; m_resp = n_resp; m_resp_pop = n_pop; m_rdata = n_rdata;
      m_rx_full = n_full; m_irq_en = n_irq_en;
      prev_pop = rx_pop;
    end
  end

  // One bus access; entered and left 1 time unit after a rising edge.
  task automatic applyStimulus(input bit wr, input logic [1:0] addr, input logic [31:0] wdata,
                               input logic [3:0] wstrb, output logic [31:0] rdata, output int latency);
    int n;
    bit done;
    bus.mem_valid = 1'b1; bus.mem_write = wr; bus.mem_addr = addr;
    bus.mem_wdata = wdata; bus.mem_wstrb = wstrb;
    n = 0; done = 0; rdata = 32'h0;
    while (!done && n < 50) begin
      @(negedge clk);
      if (bus.mem_ready === 1'b1) begin
        done = 1; rdata = bus.mem_rdata; last_ready_cyc = cyc;
      end else begin
        n++;
      end
    end
    latency = n;
    if (!done) checkOutput("bus_timeout", {31'b0, bus.mem_ready}, 32'h1);
    @(posedge clk); #1;
    bus.mem_valid = 1'b0; bus.mem_write = 1'b0;
  endtask

  task automatic busRead(input logic [1:0] addr, input logic [31:0] expected, input string name);
    logic [31:0] rd;
    int lat;
    applyStimulus(1'b0, addr, 32'h0, 4'h0, rd, lat);
    checkOutput({name, "_rdata"}, rd, expected);
    checkOutput({name, "_latency"}, lat, 32'd1);
  endtask

  task automatic busWrite(input logic [1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int exp_latency, input string name);
    logic [31:0] rd;
    int lat;
    applyStimulus(1'b1, addr, data, strb, rd, lat);
    checkOutput({name, "_latency"}, lat, exp_latency);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitIrq(input bit level, input int budget);
    for (int i = 0; i < budget && irq !== level; i++) idleCycles(1);
    checkOutput("irq_wait", {31'b0, irq}, {31'b0, level});
  endtask

  task automatic waitTxSent(input int count, input int budget);
    for (int i = 0; i < budget && tx_sent.size() < count; i++) idleCycles(1);
    checkOutput("tx_sent_count", tx_sent.size(), count);
  endtask

  task automatic applyReset(input int n);
    rst_n = 1'b0;
    bus.mem_valid = 1'b0; bus.mem_write = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    checkOutput("reset_mem_ready", {31'b0, bus.mem_ready}, 32'h0);
    checkOutput("reset_mem_rdata", bus.mem_rdata, 32'h0);
    checkOutput("reset_tx_available", {31'b0, tx_available}, 32'h0);
    checkOutput("reset_tx_data", {24'b0, tx_data}, 32'h0);
    checkOutput("reset_rx_pop", {31'b0, rx_pop}, 32'h0);
    checkOutput("reset_irq", {31'b0, irq}, 32'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [5:0]  pop_pattern;
    logic [31:0] status;
    int          lat;
    int          stall_lat;
    int          tries;

    bus.mem_valid = 1'b0; bus.mem_write = 1'b0; bus.mem_addr = 2'd0;
    bus.mem_wdata = 32'h0; bus.mem_wstrb = 4'h0;

    applyReset(3);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pop_pattern[i] = rx_pop;
    end
    checkOutput("rx_pop_pattern", {26'b0, pop_pattern}, 32'h15);
    idleCycles(1);

    busRead(2'd1, 32'h0, "status_after_reset");
    checkOutput("irq_after_reset", {31'b0, irq}, 32'h0);

    tx_ack_delay = 2;
    busWrite(2'd0, 32'h41, 4'h1, 1, "tx_write_single");
    waitTxSent(1, 30);
    checkOutput("tx_byte_0", {24'b0, tx_sent[0]}, 32'h41);
    idleCycles(3);

    tx_ack_delay = 9;
    busWrite(2'd0, 32'h41, 4'h1, 1, "tx_write_first");
    applyStimulus(1'b1, 2'd0, 32'h42, 4'h1, status, stall_lat);
    checkOutput("tx_write_stalled_latency", stall_lat, 32'd10);
    checkOutput("tx_stall_ready_after_ack", last_ready_cyc, last_ack_cyc + 1);
    waitTxSent(3, 40);
    checkOutput("tx_byte_1", {24'b0, tx_sent[1]}, 32'h41);
    checkOutput("tx_byte_2", {24'b0, tx_sent[2]}, 32'h42);
    idleCycles(3);

    busWrite(2'd0, 32'h77, 4'h0, 1, "data_write_no_strobe");
    busRead(2'd1, 32'h0, "status_no_push");
    busWrite(2'd3, 32'hFFFF_FFFF, 4'hF, 1, "reserved_write");
    busRead(2'd3, 32'h0, "reserved_read");

    busWrite(2'd2, 32'h1, 4'h1, 1, "ctrl_enable");
    busWrite(2'd2, 32'h0, 4'h0, 1, "ctrl_no_strobe");
    busRead(2'd2, 32'h1, "ctrl_read");

    rx_q.push_back(8'h5A);
    waitIrq(1'b1, 20);
    busRead(2'd1, 32'h5, "status_rx_full");
    checkOutput("irq_rx_full", {31'b0, irq}, 32'h1);
    busRead(2'd0, 32'h8000_005A, "data_read_5a");
    idleCycles(2);
    checkOutput("irq_after_read", {31'b0, irq}, 32'h0);
    busRead(2'd0, 32'h0, "data_read_empty");

    rx_q.push_back(8'h01); rx_q.push_back(8'h02); rx_q.push_back(8'h03);
    for (int k = 0; k < 3; k++) begin
      tries = 0;
      status = 32'h0;
      while (tries < 20 && status[0] !== 1'b1) begin
        applyStimulus(1'b0, 2'd1, 32'h0, 4'h0, status, lat);
        tries++;
      end
      checkOutput("rx_poll_ready", {31'b0, status[0]}, 32'h1);
      busRead(2'd0, 32'h8000_0001 + k, "data_read_seq");
    end
    busRead(2'd0, 32'h0, "data_read_drained");

    rx_q.push_back(8'h77);
    waitIrq(1'b1, 20);
    tx_ack_delay = 1000;
    busWrite(2'd0, 32'h99, 4'h1, 1, "tx_write_before_reset");
    busWrite(2'd0, 32'h55, 4'h0, 1, "data_write_no_strobe_full");
    checkOutput("tx_held_before_reset", {24'b0, tx_data}, 32'h99);
    applyReset(2);
    idleCycles(1);
    busRead(2'd1, 32'h0, "status_after_midop_reset");
    checkOutput("tx_available_after_reset", {31'b0, tx_available}, 32'h0);
    checkOutput("irq_after_midop_reset", {31'b0, irq}, 32'h0);

    idleCycles(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
